// File: rtl/gte_pkg.sv
// Shared types and constants for the GTE command sequencer: opcode set,
// per-opcode cycle counts, FSM state type and default step width.
package gte_pkg;

    localparam int STEP_W = 6;
    localparam int CMD_W  = 25;
    localparam int OPC_W  = 6;
    localparam int CYC_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gte_state_e;

    typedef enum logic [OPC_W-1:0] {
        OP_RTPS  = 6'h01,
        OP_NCLIP = 6'h06,
        OP_OP    = 6'h0C,
        OP_DPCS  = 6'h10,
        OP_INTPL = 6'h11,
        OP_MVMVA = 6'h12,
        OP_NCDS  = 6'h13,
        OP_CDP   = 6'h14,
        OP_NCDT  = 6'h16,
        OP_NCCS  = 6'h1B,
        OP_CC    = 6'h1C,
        OP_NCS   = 6'h1E,
        OP_NCT   = 6'h20,
        OP_SQR   = 6'h28,
        OP_DCPL  = 6'h29,
        OP_DPCT  = 6'h2A,
        OP_AVSZ3 = 6'h2D,
        OP_AVSZ4 = 6'h2E,
        OP_RTPT  = 6'h30,
        OP_GPF   = 6'h3D,
        OP_GPL   = 6'h3E,
        OP_NCCT  = 6'h3F
    } gte_opcode_e;

    // Execution length in cycles; zero marks an opcode the GTE does not implement.
    function automatic logic [CYC_W-1:0] gte_cycles(input logic [OPC_W-1:0] opc);
        logic [CYC_W-1:0] n;
        n = '0;
        case (opc)
            OP_RTPS:  n = 8'd15;
            OP_NCLIP: n = 8'd8;
            OP_OP:    n = 8'd6;
            OP_DPCS:  n = 8'd8;
            OP_INTPL: n = 8'd8;
            OP_MVMVA: n = 8'd8;
            OP_NCDS:  n = 8'd19;
            OP_CDP:   n = 8'd13;
            OP_NCDT:  n = 8'd44;
            OP_NCCS:  n = 8'd17;
            OP_CC:    n = 8'd11;
            OP_NCS:   n = 8'd14;
            OP_NCT:   n = 8'd30;
            OP_SQR:   n = 8'd5;
            OP_DCPL:  n = 8'd8;
            OP_DPCT:  n = 8'd17;
            OP_AVSZ3: n = 8'd5;
            OP_AVSZ4: n = 8'd6;
            OP_RTPT:  n = 8'd23;
            OP_GPF:   n = 8'd5;
            OP_GPL:   n = 8'd5;
            OP_NCCT:  n = 8'd39;
            default:  n = 8'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/gte_cmd_seq_up_counter.sv
// Micro-step counter for the GTE sequencer; clear has priority over count.
module up_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/gte_cmd_seq.sv
// GTE COP2 command sequencer: accepts a command, runs it for its table-defined
// number of cycles while driving the micro-step index, then pulses done.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// upstream keeps cmd_valid and cmd stable until that edge.
module gte_cmd_seq #(
    parameter int STEP_W = gte_pkg::STEP_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    input  logic [24:0]          cmd,
    output logic                 cmd_ready,
    input  logic                 abort,
    input  logic                 cpu_gte_access,
    output logic                 busy,
    output logic                 stall,
    output logic [STEP_W-1:0]    step,
    output logic [24:0]          op,
    output logic                 done,
    output logic                 illegal,
    output gte_pkg::gte_state_e  dbg_state
);

    import gte_pkg::*;

    gte_state_e          r_state;
    gte_state_e          w_state_nxt;
    logic [CMD_W-1:0]    r_op;
    logic [STEP_W-1:0]   r_ncyc;
    logic                r_illegal;

    logic [CYC_W-1:0]    w_cycles;
    logic                w_legal;
    logic                w_accept;
    logic                w_run;
    logic                w_last;
    logic                w_cnt_clr;
    logic [STEP_W-1:0]   w_step;

    assign w_cycles = gte_cycles(cmd[OPC_W-1:0]);
    assign w_legal  = (w_cycles != '0);
    assign w_accept = cmd_valid && cmd_ready;
    assign w_run    = (r_state == ST_RUN);
    assign w_last   = (w_step == (r_ncyc - STEP_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept && w_legal) w_state_nxt = ST_RUN;
                ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: cmd_ready = !abort;
            ST_RUN: begin
                busy = 1'b1;
                done = w_last && !abort;
            end
            default: ;
        endcase
    end

    // Unknown opcodes still land in op so software can see what was rejected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op   <= '0;
            r_ncyc <= '0;
        end else if (w_accept) begin
            r_op   <= cmd;
            r_ncyc <= STEP_W'(w_cycles);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_legal;
        end
    end

    assign w_cnt_clr = abort || (w_run && w_last) || w_accept;

    up_counter #(
        .W (STEP_W)
    ) u_step_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_run),
        .i_clr   (w_cnt_clr),
        .o_count (w_step)
    );

    assign stall     = busy && cpu_gte_access;
    assign step      = w_step;
    assign op        = r_op;
    assign illegal   = r_illegal;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gte_cmd_seq.sv
// Bench for gte_cmd_seq: opcode table sweep, hand-written corner sequences and
// a randomized run, all checked against a timeline-based reference model.
module tb_gte_cmd_seq;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                cmd_valid = 1'b0;
    logic [24:0]         cmd = '0;
    logic                cmd_ready;
    logic                abort = 1'b0;
    logic                cpu_gte_access = 1'b0;
    logic                busy;
    logic                stall;
    logic [5:0]          step;
    logic [24:0]         op;
    logic                done;
    logic                illegal;
    gte_pkg::gte_state_e dbg_state;

    int checks = 0;
    int failures = 0;

    gte_cmd_seq #(.STEP_W(6)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd            (cmd),
        .cmd_ready      (cmd_ready),
        .abort          (abort),
        .cpu_gte_access (cpu_gte_access),
        .busy           (busy),
        .stall          (stall),
        .step           (step),
        .op             (op),
        .done           (done),
        .illegal        (illegal),
        .dbg_state      (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] opc;
        int         exp_busy;
        bit         exp_ill;
    } vec_t;

    vec_t vecs[$];
    int   ref_n[64];

    // Reference model: the command is described by when it was accepted and
    // how long it lasts; every output follows from the current cycle number.
    int          t = 0;
    int          acc_t = -1000;
    int          acc_n = 0;
    int          ill_t = -1000;
    logic [24:0] m_op = '0;
    bit          last_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", nm, t, act, exp);
        end
    endtask

    task automatic model_reset();
        acc_t = -1000;
        acc_n = 0;
        ill_t = -1000;
        m_op  = '0;
    endtask

    task automatic model_check();
        bit m_run, m_done_cyc, e_ready;
        m_run      = (acc_n > 0) && (t > acc_t) && (t <= acc_t + acc_n);
        m_done_cyc = (acc_n > 0) && (t == acc_t + acc_n + 1);
        e_ready    = !abort && !m_run && !m_done_cyc;
        chk("m_busy", 32'(busy), 32'(m_run));
        chk("m_step", 32'(step), m_run ? 32'(t - acc_t - 1) : 32'd0);
        chk("m_done", 32'(done), 32'(m_run && (t == acc_t + acc_n) && !abort));
        chk("m_ready", 32'(cmd_ready), 32'(e_ready));
        chk("m_illegal", 32'(illegal), 32'(t == ill_t + 1));
        chk("m_stall", 32'(stall), 32'(m_run && cpu_gte_access));
        chk("m_op", 32'(op), 32'(m_op));
        last_acc = cmd_valid && e_ready;
        if (abort) begin
            acc_n = 0;
        end else if (last_acc) begin
            m_op = cmd;
            if (ref_n[cmd[5:0]] > 0) begin
                acc_t = t;
                acc_n = ref_n[cmd[5:0]];
            end else begin
                ill_t = t;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send(input logic [5:0] opc);
        cmd       = {19'($urandom), opc};
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int busy_cnt, ill_cnt, done_cnt, k;
        logic [24:0] saved;
        bit pend;

        vecs = '{
            '{6'h01, 15, 0}, '{6'h06, 8, 0},  '{6'h0C, 6, 0},  '{6'h10, 8, 0},
            '{6'h11, 8, 0},  '{6'h12, 8, 0},  '{6'h13, 19, 0}, '{6'h14, 13, 0},
            '{6'h16, 44, 0}, '{6'h1B, 17, 0}, '{6'h1C, 11, 0}, '{6'h1E, 14, 0},
            '{6'h20, 30, 0}, '{6'h28, 5, 0},  '{6'h29, 8, 0},  '{6'h2A, 17, 0},
            '{6'h2D, 5, 0},  '{6'h2E, 6, 0},  '{6'h30, 23, 0}, '{6'h3D, 5, 0},
            '{6'h3E, 5, 0},  '{6'h3F, 39, 0},
            '{6'h00, 0, 1},  '{6'h07, 0, 1},  '{6'h15, 0, 1},  '{6'h3C, 0, 1}
        };
        for (int i = 0; i < 64; i++) ref_n[i] = 0;
        foreach (vecs[i]) ref_n[vecs[i].opc] = vecs[i].exp_busy;

        // Reset state while rst is held
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        settle();
        chk("rst_ready_after", 32'(cmd_ready), 32'd1);

        // Opcode 01 walk-through
        send(6'h01);
        for (int s = 0; s < 15; s++) begin
            settle();
            chk("s01_busy", 32'(busy), 32'd1);
            chk("s01_step", 32'(step), 32'(s));
            chk("s01_done", 32'(done), 32'(s == 14));
            tick();
        end
        settle();
        chk("s01_done_state_ready", 32'(cmd_ready), 32'd0);
        chk("s01_done_state_busy", 32'(busy), 32'd0);
        tick();
        settle();
        chk("s01_ready_again", 32'(cmd_ready), 32'd1);

        // Opcode 16 with a CPU access at step 20
        send(6'h16);
        for (int s = 0; s < 44; s++) begin
            cpu_gte_access = (s == 20);
            settle();
            if (s == 20) chk("s16_stall", 32'(stall), 32'd1);
            if (s == 43) chk("s16_done", 32'(done), 32'd1);
            tick();
        end
        cpu_gte_access = 1'b0;
        idle_ticks(1);

        // Abort at step 3 of opcode 30
        send(6'h30);
        idle_ticks(3);
        abort = 1'b1;
        settle();
        chk("ab_step3", 32'(step), 32'd3);
        chk("ab_no_done", 32'(done), 32'd0);
        tick();
        abort = 1'b0;
        settle();
        chk("ab_busy", 32'(busy), 32'd0);
        chk("ab_step", 32'(step), 32'd0);
        chk("ab_ready", 32'(cmd_ready), 32'd1);
        idle_ticks(2);

        // Unknown opcode 07, then an immediate legal command
        send(6'h07);
        saved = cmd;
        settle();
        chk("il_pulse", 32'(illegal), 32'd1);
        chk("il_busy", 32'(busy), 32'd0);
        chk("il_op", 32'(op), 32'(saved));
        chk("il_ready", 32'(cmd_ready), 32'd1);
        send(6'h0C);
        settle();
        chk("il_pulse_end", 32'(illegal), 32'd0);
        chk("il_next_busy", 32'(busy), 32'd1);
        idle_ticks(8);

        // Back-to-back: 28 then held 2D, accept spacing N+2
        send(6'h28);
        cmd       = {19'($urandom), 6'h2D};
        cmd_valid = 1'b1;
        k = 1;
        settle();
        while (!cmd_ready && k < 20) begin
            tick();
            k++;
            settle();
        end
        chk("b2b_spacing", 32'(k), 32'd7);
        tick();
        cmd_valid = 1'b0;
        idle_ticks(7);
        abort     = 1'b1;
        cmd       = {19'($urandom), 6'h01};
        cmd_valid = 1'b1;
        settle();
        chk("ab_cv_ready", 32'(cmd_ready), 32'd0);
        tick();
        abort     = 1'b0;
        cmd_valid = 1'b0;
        settle();
        chk("ab_cv_dropped", 32'(busy), 32'd0);
        idle_ticks(2);

        // Asynchronous reset in the middle of opcode 3F
        send(6'h3F);
        idle_ticks(10);
        cpu_gte_access = 1'b1;
        rst = 1'b1;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_stall", 32'(stall), 32'd0);
        chk("ar_step", 32'(step), 32'd0);
        chk("ar_op", 32'(op), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_illegal", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_gte_access = 1'b0;
        model_reset();
        settle();
        chk("ar_ready", 32'(cmd_ready), 32'd1);
        idle_ticks(2);

        // Table sweep over every opcode entry
        foreach (vecs[i]) begin
            send(vecs[i].opc);
            busy_cnt = 0;
            ill_cnt  = 0;
            done_cnt = 0;
            for (int c = 0; c < 48; c++) begin
                settle();
                busy_cnt += int'(busy);
                ill_cnt  += int'(illegal);
                done_cnt += int'(done);
                tick();
            end
            chk($sformatf("tbl_busy_%02h", vecs[i].opc), 32'(busy_cnt), 32'(vecs[i].exp_busy));
            chk($sformatf("tbl_ill_%02h", vecs[i].opc), 32'(ill_cnt), 32'(vecs[i].exp_ill));
            chk($sformatf("tbl_done_%02h", vecs[i].opc), 32'(done_cnt), 32'(!vecs[i].exp_ill));
        end

        // Randomized traffic; upstream holds a command until it is taken
        pend = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                cmd_valid = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 9) < 7)
                    cmd = {19'($urandom), vecs[$urandom_range(0, 21)].opc};
                else
                    cmd = 25'($urandom);
            end
            abort          = ($urandom_range(0, 24) == 0);
            cpu_gte_access = 1'($urandom);
            tick();
            pend = cmd_valid && !last_acc;
        end
        cmd_valid      = 1'b0;
        abort          = 1'b0;
        cpu_gte_access = 1'b0;
        idle_ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gte_cmd_seq.md
GTE_CMD_SEQ -- requirements
Module: gte_cmd_seq

Interface
REQ-001 Parameter STEP_W, default 6, is the width of the step counter and the cycle-count table entries.
REQ-002 Port clk, input, 1, is the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1, is the asynchronous active-high reset.
REQ-004 Port cmd_valid, input, 1, means the CPU offers a COP2 command this cycle.
REQ-005 Port cmd, input, 25, is the COP2 command word: bits [5:0] opcode, [19] sf, [10] lm, rest passed through.
REQ-006 Port cmd_ready, output, 1, means the sequencer accepts a command this cycle.
REQ-007 Port abort, input, 1, is a synchronous cancel of any command in flight.
REQ-008 Port cpu_gte_access, input, 1, means the CPU is reading or writing a GTE register this cycle.
REQ-009 Port busy, output, 1, means a legal command is executing.
REQ-010 Port stall, output, 1, is the CPU pipeline stall request.
REQ-011 Port step, output, STEP_W, is the datapath micro-step index.
REQ-012 Port op, output, 25, is the latched command word.
REQ-013 Port done, output, 1, is a one-cycle completion pulse.
REQ-014 Port illegal, output, 1, is a one-cycle unknown-opcode pulse.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; cmd_ready = (state==IDLE) && !abort.
REQ-016 Accept (cmd_valid && cmd_ready) SHALL latch cmd into op and look up cycle count N from the opcode table.
REQ-017 Opcode table (hex opcode:N) SHALL be 01:15, 06:8, 0C:6, 10:8, 11:8, 12:8, 13:19, 14:13, 16:44, 1B:17, 1C:11, 1E:14, 20:30, 28:5, 29:8, 2A:17, 2D:5, 2E:6, 30:23, 3D:5, 3E:5, 3F:39.
REQ-018 Legal accept SHALL move IDLE->RUN next cycle, with step=0 in the first RUN cycle.
REQ-019 In RUN, step SHALL increment by 1 each cycle; busy=1 for exactly N cycles (step 0..N-1).
REQ-020 In the RUN cycle with step==N-1, done SHALL pulse 1; the FSM goes to DONE next.
REQ-021 DONE SHALL last one cycle with busy=0 and cmd_ready=0, then return to IDLE; minimum accept-to-accept spacing is N+2 cycles.
REQ-022 Unknown-opcode accept SHALL pulse illegal the next cycle, stay IDLE, leave busy=0, and still update op.
REQ-023 stall SHALL be combinational: busy && cpu_gte_access.
REQ-024 abort SHALL force IDLE and clear step the next cycle from any state, with no done pulse.
REQ-025 When abort and cmd_valid are both high, abort SHALL win and the command SHALL be dropped.
REQ-026 cmd_valid in RUN or DONE SHALL be ignored; the upstream holds it until cmd_ready.
REQ-027 step SHALL never exceed N-1; it holds 0 outside RUN.

Reset
REQ-028 rst SHALL immediately set state=IDLE and step=0, op=0, busy=0, done=0, illegal=0, stall=0.
REQ-029 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-030 rst during RUN SHALL discard the command with no done pulse.

Structure
REQ-031 Package gte_pkg SHALL hold the opcode enum, the cycle-count constants/lookup function, the state typedef and STEP_W.
REQ-032 step SHALL be one up_counter sub-module instance: en = RUN, clr = abort, leaving RUN, or accept; it is the single sub-module.
REQ-033 op and N SHALL be held in enable-loaded registers; no other storage.

Verification
REQ-034 Scenario: reset, then cmd opcode 01 -> busy 15 cycles, step 0..14, done at step 14, cmd_ready 1 two cycles later.
REQ-035 Scenario: opcode 16, then cpu_gte_access high at step 20 -> stall=1 that cycle; done at step 43.
REQ-036 Scenario: abort at step 3 of opcode 30 -> next cycle IDLE, step=0, no done, cmd_ready=1.
REQ-037 Scenario: opcode 07 -> illegal pulse one cycle, busy stays 0, op=cmd, next command accepted immediately.
REQ-038 Scenario: opcode 28 then cmd_valid held with opcode 2D -> second accept exactly 7 cycles after the first; abort+cmd_valid together -> no accept.
REQ-039 Scenario: rst asserted mid-RUN of opcode 3F -> all outputs 0 asynchronously, cmd_ready 1 after release.
